// File: rtl/df_2comp_to_sm_serial.sv
// Bit-serial two's-complement to sign-magnitude converter, LSB first.
// Negative samples use the "copy through the first 1, invert above it" rule.
module df_2comp_to_sm_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH:0]   in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_sign,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic              seen_one_q, seen_one_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_mag_q, out_mag_d;
  logic              out_sign_q, out_sign_d;
  logic              out_ovf_q, out_ovf_d;

  logic             bit_in;
  logic             mag_bit;
  logic             seen_nxt;
  logic [WIDTH-1:0] sreg_shift;

  always_comb begin
    bit_in      = sreg_q[0];
    mag_bit     = sign_q ? (bit_in ^ seen_one_q) : bit_in;
    seen_nxt    = seen_one_q | (sign_q & bit_in);
    // Magnitude bits refill the shift register from the top as input bits leave the bottom.
    sreg_shift  = {mag_bit, sreg_q[WIDTH-1:1]};

    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    seen_one_d  = seen_one_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_mag_d   = out_mag_q;
    out_sign_d  = out_sign_q;
    out_ovf_d   = out_ovf_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sreg_d     = in_data[WIDTH-1:0];
          sign_d     = in_data[WIDTH];
          cnt_d      = '0;
          seen_one_d = 1'b0;
          in_ready_d = 1'b0;
          state_d    = StBusy;
        end
      end
      StBusy: begin
        sreg_d     = sreg_shift;
        seen_one_d = seen_nxt;
        cnt_d      = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          out_sign_d  = sign_q;
          // A negative input with no 1 bit at all is -2^WIDTH: saturate.
          if (sign_q && !seen_nxt) begin
            out_mag_d = '1;
            out_ovf_d = 1'b1;
          end else begin
            out_mag_d = sreg_shift;
            out_ovf_d = 1'b0;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = StIdle;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      sreg_q      <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      seen_one_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_sign_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      seen_one_q  <= seen_one_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_mag_q   <= out_mag_d;
      out_sign_q  <= out_sign_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_sign  = out_sign_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_df_2comp_to_sm_serial.sv
// Self-checking bench for df_2comp_to_sm_serial: vector table, hand sequences and a full sweep,
// all results checked through an expected-value queue.
module tb_df_2comp_to_sm_serial;

  typedef struct {
    logic [7:0] mag;
    logic       sign;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [8:0] din;
    logic [7:0] mag;
    logic       sign;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_mag;
  logic       out_sign;
  logic       out_ovf;
  logic       out_valid;
  logic       out_ready = 1'b1;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   ready_mode = 1;
  logic prev_valid = 1'b0;
  exp_t sbq[$];
  vec_t vecs[7];

  df_2comp_to_sm_serial #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_mag  (out_mag),
    .out_sign (out_sign),
    .out_ovf  (out_ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_of(input logic [8:0] d);
    exp_t e;
    int   v;
    v = int'($signed(d));
    e.ovf  = 1'b0;
    e.sign = (v < 0);
    if (v == -256) begin
      e.mag = 8'hFF;
      e.ovf = 1'b1;
    end else if (v < 0) begin
      e.mag = 8'(-v);
    end else begin
      e.mag = 8'(v);
    end
    return e;
  endfunction

  // Scoreboard: every valid cycle must show the oldest pending result, which also
  // covers output stability under backpressure.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        check("in_ready_low_while_valid", int'(in_ready), 0);
        if (!prev_valid) check("latency", cyc - accept_cyc, 8);
        check("result_pending", int'(sbq.size() > 0), 1);
        if (sbq.size() > 0) begin
          check("out_mag", int'(out_mag), int'(sbq[0].mag));
          check("out_sign", int'(out_sign), int'(sbq[0].sign));
          check("out_ovf", int'(out_ovf), int'(sbq[0].ovf));
          if (out_ready) void'(sbq.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input logic [8:0] d, input exp_t e);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back(e);
        accept_cyc = cyc + 1;
        got = 1'b1;
      end
    end
    check("accept_timeout", int'(got), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sbq.size() > 0; i++) @(negedge clk);
    check("drain", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("out_valid_timeout", int'(seen), 1);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{din: 9'h07F, mag: 8'd127, sign: 1'b0, ovf: 1'b0};
    vecs[1] = '{din: 9'h181, mag: 8'd127, sign: 1'b1, ovf: 1'b0};
    vecs[2] = '{din: 9'h000, mag: 8'd0,   sign: 1'b0, ovf: 1'b0};
    vecs[3] = '{din: 9'h100, mag: 8'hFF,  sign: 1'b1, ovf: 1'b1};
    vecs[4] = '{din: 9'h0FF, mag: 8'hFF,  sign: 1'b0, ovf: 1'b0};
    vecs[5] = '{din: 9'h1FE, mag: 8'h02,  sign: 1'b1, ovf: 1'b0};
    vecs[6] = '{din: 9'h155, mag: 8'hAB,  sign: 1'b1, ovf: 1'b0};

    #12;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_mag", int'(out_mag), 0);
    check("rst_out_sign", int'(out_sign), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    @(negedge clk);
    rst = 1'b0;

    // -1 with out_ready high; handshake edge must drop valid and raise ready together.
    ready_mode = 1;
    send(9'h1FF, '{mag: 8'h01, sign: 1'b1, ovf: 1'b0});
    wait_valid();
    @(negedge clk);
    check("valid_fell_after_accept", int'(out_valid), 0);
    check("in_ready_back", int'(in_ready), 1);
    drain();

    for (int i = 0; i < 7; i++) begin
      e = '{mag: vecs[i].mag, sign: vecs[i].sign, ovf: vecs[i].ovf};
      send(vecs[i].din, e);
    end
    drain();

    // Backpressure: a held result must not let a new sample in.
    ready_mode = 0;
    send(9'h1C0, '{mag: 8'h40, sign: 1'b1, ovf: 1'b0});
    wait_valid();
    in_data  = 9'h001;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid_held", int'(out_valid), 1);
      check("stall_in_ready_low", int'(in_ready), 0);
    end
    ready_mode = 1;
    send(9'h001, '{mag: 8'h01, sign: 1'b0, ovf: 1'b0});
    drain();

    // Asynchronous reset three cycles into a conversion.
    send(9'h055, model_of(9'h055));
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_out_mag", int'(out_mag), 0);
    check("abort_out_sign", int'(out_sign), 0);
    check("abort_out_ovf", int'(out_ovf), 0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("no_valid_after_abort", int'(out_valid), 0);
    send(9'h1FE, '{mag: 8'h02, sign: 1'b1, ovf: 1'b0});
    drain();

    // Full input sweep with random downstream stalls.
    ready_mode = 2;
    for (int i = 0; i < 512; i++) send(9'(i), model_of(9'(i)));
    drain();
    ready_mode = 1;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
